// File: rtl/spram_pkg.sv
// spram_pkg: shared defaults and control decode for the single-port RAM.
package spram_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 32;
  localparam int DEFAULT_ADDR_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } ctrl_e;
  // cs, we are active-low; an unselected chip is idle whatever we says.
  function automatic ctrl_e decode_ctrl(input logic cs, input logic we);
    return cs ? IDLE : (we ? READ : WRITE);
  endfunction
endpackage

// File: rtl/single_port_ram_core.sv
// single_port_ram_core: word storage plus the registered read port.
// SPRAM_ZERO_ON_RESET_EN makes reset also clear every stored word.
module single_port_ram_core
  import spram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  ctrl_e                 i_op,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  // One extra bit lets DEPTH == 2**ADDR_WIDTH be compared without overflow.
  assign w_in_range = {1'b0, i_addr} < LIMIT;
  assign w_idx      = i_addr[IDX_W-1:0];
  assign o_rdata    = r_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rdata <= '0;
    else if (i_op == READ)
      r_rdata <= w_in_range ? r_mem[w_idx] : '0;
  end
`ifdef SPRAM_ZERO_ON_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_op == WRITE && w_in_range) begin
      r_mem[w_idx] <= i_wdata;
    end
  end
`else
  // Storage has no reset; sampling rst_n here only blocks writes while held.
  always_ff @(posedge clk) begin
    if (rst_n && i_op == WRITE && w_in_range)
      r_mem[w_idx] <= i_wdata;
  end
`endif
endmodule

// File: rtl/single_port_ram.sv
// single_port_ram: control decode and tri-state data bus around the core.
// Optional SPRAM_ZERO_ON_RESET_EN clears the memory contents on reset.
module single_port_ram
  import spram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);
  ctrl_e                 w_op;
  logic                  w_drive;
  logic [DATA_WIDTH-1:0] w_rdata;
  assign w_op    = decode_ctrl(cs, we);
  // we is part of the enable so external write data can never contend.
  assign w_drive = !cs && we && !oe;
  assign data    = w_drive ? w_rdata : 'z;
  single_port_ram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_op   (w_op),
    .i_addr (addr),
    .i_wdata(data),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_single_port_ram.sv
// tb_single_port_ram: directed test of single_port_ram against a word-level model.
// The bus is pulled up, so an undriven bus reads as all ones.
module tb_single_port_ram;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 16;
  logic clk = 0, rst_n = 1, cs = 1, we = 1, oe = 1, tb_en = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] tb_data = '0;
  tri1  [DW-1:0] data;
  int n_chk = 0, n_err = 0;
  logic [DW-1:0] vals [10] = '{32'h12153524, 32'hC0895E81, 32'h8484D609, 32'hB1F05663,
                               32'h06B97B0D, 32'h46DF998D, 32'hB2C28465, 32'h89375212,
                               32'h00F3E301, 32'h06D7CD0D};
  assign data = tb_en ? tb_data : 'z;
  always #5 clk = ~clk;

  single_port_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .data (data),
    .cs   (cs),
    .we   (we),
    .oe   (oe)
  );

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_val [DEPTH];
  logic [DW-1:0] m_q = '0;
  bit            m_qk = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q  <= '0;
      m_qk <= 1;
`ifdef SPRAM_ZERO_ON_RESET_EN
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] <= '0;
        m_val[i] <= 1;
      end
`endif
    end else if (!cs) begin
      if (!we) begin
        if (int'(addr) < DEPTH) begin
          m_mem[int'(addr)] <= tb_data;
          m_val[int'(addr)] <= 1;
        end
      end else if (int'(addr) < DEPTH) begin
        m_q  <= m_mem[int'(addr)];
        m_qk <= m_val[int'(addr)];
      end else begin
        m_q  <= '0;
        m_qk <= 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp();
    logic [DW-1:0] exp;
    bit drive;
    drive = !cs && we && !oe;
    if (drive && !m_qk) return;
    exp = drive ? m_q : (tb_en ? tb_data : '1);
    chk("bus_model", data, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    cmp();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 0; cs = 0; we = 1; oe = 0;
    #2 chk("rst_drive_zero", data, 32'h0);
    oe = 1;
    #1 chk("rst_hiz", data, '1);
    cyc(); cyc();
    rst_n = 1;
    we = 0; oe = 0; tb_en = 1;
    for (int i = 0; i < 10; i++) begin
      addr = AW'(i); tb_data = vals[i]; cyc();
    end
    tb_en = 0; we = 1;
    for (int i = 0; i < 10; i++) begin
      addr = AW'(i); cyc();
      chk($sformatf("rd%0d", i), data, vals[i]);
    end
    we = 0; tb_en = 1; addr = 16'd40; tb_data = 32'hDEADBEEF; cyc();
    tb_en = 0; we = 1; cyc();
    chk("rd_oor", data, 32'h0);
    addr = 16'd8; cyc();
    chk("rd8_unaliased", data, 32'h00F3E301);
    we = 0; tb_en = 1; addr = 16'd5; tb_data = 32'hA5A5A5A5; cyc();
    cs = 1; tb_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("cs1_tb_bus", data, 32'h0);
    end
    tb_en = 0; we = 1;
    #1 chk("cs1_hiz", data, '1);
    cs = 0; cyc();
    chk("rd5_after_cs1", data, 32'hA5A5A5A5);
    we = 0; tb_en = 1; addr = 16'd2; tb_data = 32'h13572468; cyc();
    tb_en = 0; we = 1;
    #1 chk("hold_after_wr", data, 32'hA5A5A5A5);
    cyc();
    chk("rd_just_written", data, 32'h13572468);
    we = 0; tb_en = 1; addr = 16'd3; tb_data = 32'h1; cyc();
    tb_en = 0; we = 1; cyc();
    chk("rd3", data, 32'h1);
    #2 rst_n = 0;
    #1 chk("rst_mid_read", data, 32'h0);
    we = 0; tb_en = 1; addr = 16'd4; tb_data = 32'h77; cyc();
    rst_n = 1; tb_en = 0; we = 1; cyc();
`ifdef SPRAM_ZERO_ON_RESET_EN
    chk("rd4_no_wr_in_rst", data, 32'h0);
`else
    chk("rd4_no_wr_in_rst", data, 32'h06B97B0D);
`endif
    we = 0; tb_en = 1; addr = 16'd7; tb_data = 32'hFFFFFFFF; cyc();
    tb_en = 0; we = 1; cs = 1;
    #1 rst_n = 0;
    cyc();
    rst_n = 1; cs = 0; cyc();
`ifdef SPRAM_ZERO_ON_RESET_EN
    chk("rd7_after_rst", data, 32'h0);
`else
    chk("rd7_after_rst", data, 32'hFFFFFFFF);
`endif
    addr = 16'd9; cyc();
    cs = 1; cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
